prog_truth_table: RTL and testbench

PROG_TRUTH_TABLE -- requirements
Module: prog_truth_table

---
 rtl/prog_tt_pkg.sv | 16 +
 rtl/prog_tt_persist.sv | 31 +++
 rtl/prog_truth_table.sv | 116 +++++++++++
 tb/tb_prog_truth_table.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_tt_pkg.sv
// rtl/prog_tt_pkg.sv - shared load FSM state type and table depth helper for prog_truth_table
package prog_tt_pkg;

  // Serial table load sequencing: idle/run, shifting bits in, one-cycle commit
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } tt_state_e;

  // Number of rows (table bits) for n logic inputs
  function automatic int unsigned tt_depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/prog_tt_persist.sv
// rtl/prog_tt_persist.sv - persistence filter: out follows raw only after PERSIST consecutive differing edges
module prog_tt_persist #(
  parameter int unsigned PERSIST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out
);

  localparam int unsigned CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] LIMIT = CW'(PERSIST - 1);

  logic [CW-1:0] cnt_q;

  // Count edges where raw disagrees with out; flip out on the PERSIST-th one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out   <= 1'b0;
    end else if (raw == out) begin
      cnt_q <= '0;
    end else if (cnt_q == LIMIT) begin
      out   <= raw;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/prog_truth_table.sv
// rtl/prog_truth_table.sv - programmable truth table with serial load port; PROG_TT_PERSIST_EN enables output filter
module prog_truth_table
  import prog_tt_pkg::*;
#(
  parameter int unsigned           N_IN        = 3,
  parameter logic [2**N_IN-1:0]    RESET_TABLE = 8'hA3,
  parameter int unsigned           PERSIST     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            out
);

  localparam int unsigned       DEPTH    = tt_depth(N_IN);
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DEPTH - 1);

  tt_state_e        state_q, state_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N_IN-1:0]  in_q;
  logic             raw;

  // Table MSB is row 0, so row k lives at bit DEPTH-1-k, which is ~k
  assign raw = table_q[~in_q];

  // Register inputs, load FSM state, shadow and active table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      table_q  <= RESET_TABLE;
      shadow_q <= '0;
      count_q  <= '0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      table_q  <= table_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      in_q     <= in;
    end
  end

  // Load FSM: shift bits MSB-first into shadow, swap into table only at COMMIT
  always_comb begin
    state_d   = state_q;
    table_d   = table_q;
    shadow_d  = shadow_q;
    count_d   = count_q;
    cfg_ready = 1'b1;
    cfg_done  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (cfg_valid) begin
          shadow_d = {shadow_q[DEPTH-2:0], cfg_bit};
          count_d  = CNT_W'(1);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          count_d = '0;
          state_d = RUN;
        end else if (cfg_valid) begin
          shadow_d = {shadow_q[DEPTH-2:0], cfg_bit};
          count_d  = count_q + CNT_W'(1);
          if (count_q == LAST_BIT) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        cfg_ready = 1'b0;
        cfg_done  = 1'b1;
        table_d   = shadow_q;
        count_d   = '0;
        state_d   = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

`ifdef PROG_TT_PERSIST_EN
  prog_tt_persist #(
    .PERSIST (PERSIST)
  ) u_persist (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .out   (out)
  );
`else
  // PERSIST has no effect without the filter; keep it referenced
  if (PERSIST == 0) begin : g_persist_ignored
  end

  // Unfiltered output: register raw result every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= raw;
    end
  end
`endif

endmodule

// File: tb/tb_prog_truth_table.sv
// tb/tb_prog_truth_table.sv - randomized and directed check of prog_truth_table against a behavioural model
module tb_prog_truth_table;

  localparam int          DEPTH     = 8;
  localparam int          P         = 4;
  localparam logic [7:0]  RST_TABLE = 8'hA3;
`ifdef PROG_TT_PERSIST_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] in = 3'b000;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_abort = 1'b0;
  logic       cfg_ready;
  logic       cfg_done;
  logic       out;

  int tests = 0;
  int fails = 0;

  // model state
  logic [7:0] m_table;
  logic [2:0] m_inq;
  logic       m_out;
  bit         m_loading;
  bit         m_pending;
  bit         m_bits[$];
  bit         m_hist[$];

  prog_truth_table #(
    .N_IN        (3),
    .RESET_TABLE (RST_TABLE),
    .PERSIST     (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"}, out, m_out);
    check({tag, ".cfg_done"}, cfg_done, m_pending);
    check({tag, ".cfg_ready"}, cfg_ready, !m_pending);
  endtask

  task automatic model_reset();
    m_table   = RST_TABLE;
    m_inq     = 3'b000;
    m_out     = 1'b0;
    m_loading = 1'b0;
    m_pending = 1'b0;
    m_bits.delete();
    m_hist.delete();
  endtask

  // Output takes a new value once the raw result has held it for P consecutive edges
  task automatic model_edge();
    logic raw;
    bit   all_diff;
    raw = m_table[7 - int'(m_inq)];
    if (FILTER) begin
      m_hist.push_back(raw);
      if (m_hist.size() > P) void'(m_hist.pop_front());
      if (m_hist.size() == P) begin
        all_diff = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] == m_out) all_diff = 1'b0;
        if (all_diff) m_out = raw;
      end
    end else begin
      m_out = raw;
    end
    m_inq = in;
    if (m_pending) begin
      for (int i = 0; i < DEPTH; i++) m_table[DEPTH-1-i] = m_bits[i];
      m_bits.delete();
      m_pending = 1'b0;
    end else if (m_loading && cfg_abort) begin
      m_bits.delete();
      m_loading = 1'b0;
    end else if (cfg_valid) begin
      m_bits.push_back(cfg_bit);
      m_loading = 1'b1;
      if (m_bits.size() == DEPTH) begin
        m_loading = 1'b0;
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic hold_in(input logic [2:0] v, input int n, input string tag);
    in = v;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic load_bits(input logic [7:0] val, input int nbits, input bit gaps, input string tag);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        cfg_valid = 1'b0;
        for (int j = 0; j < g; j++) tick({tag, ".gap"});
      end
      cfg_valid = 1'b1;
      cfg_bit   = val[7-i];
      tick(tag);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    do_reset("reset0");
    check("reset.out_const", out, 1'b0);
    check("reset.ready_const", cfg_ready, 1'b1);

    hold_in(3'b000, 6, "row0");
    check("row0.out_const", out, 1'b1);
    hold_in(3'b001, 6, "row1");
    check("row1.out_const", out, 1'b0);
    hold_in(3'b110, 6, "row6");
    check("row6.out_const", out, 1'b1);

    hold_in(3'b000, 6, "glitch.pre");
    hold_in(3'b001, 2, "glitch.pulse");
    hold_in(3'b000, 6, "glitch.post");
    in = 3'b001;
    tick("pulse1");
    in = 3'b000;
    tick("pulse1.back");
    hold_in(3'b000, 4, "pulse1.post");

    load_bits(8'hFF, 8, 1'b1, "loadff");
    tick("loadff.commit");
    hold_in(3'b001, 6, "loadff.row1");
    check("loadff.row1_const", out, 1'b1);

    do_reset("reset1");
    in = 3'b001;
    load_bits(8'h5C, 5, 1'b0, "abort.bits");
    cfg_valid = 1'b1;
    cfg_abort = 1'b1;
    cfg_bit   = 1'b1;
    tick("abort.edge");
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    hold_in(3'b001, 8, "abort.row1");
    check("abort.row1_const", out, 1'b0);

    load_bits(8'h3C, 3, 1'b0, "partial");
    do_reset("reset2");
    hold_in(3'b000, 6, "partial.row0");
    load_bits(8'h96, 8, 1'b1, "fresh");
    tick("fresh.commit");
    for (int r = 0; r < 8; r++) hold_in(r[2:0], 6, "fresh.row");

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rand.reset");
      if ($urandom_range(0, 3) == 0) in = 3'($urandom_range(0, 7));
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_bit   = 1'($urandom_range(0, 1));
      cfg_abort = ($urandom_range(0, 15) == 0);
      tick("rand");
    end
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    hold_in(3'b010, 8, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
